tcm_enc_packer: RTL and testbench
=================================

# tcm_enc_packer

Byte-stream to 4D-symbol-word packer sitting directly upstream of `tcm_enc` in the 4D-8PSK TCM transmit path. It accepts framed bytes under valid/ready handshake and repacks them LSB-first into 8/9/10/11-bit words, selected by `icode` 0/1/2/3. It emits one word per 4D symbol (every 4th `i1sps` cycle) with `osop`/`oeop` framing over `pN` words, so its outputs wire straight to `tcm_enc` `i1sps/isop/ieop/ival/idat`.

## Interface
- `pN`, 1000, words per output packet (≥1)
- `iclk`  in  1  clock
- `ireset`  in  1  synchronous active-high reset
- `iclkena`  in  1  clock enable; when low, all state and outputs hold
- `icode`  in  2  code rate select 0..3 (word width `cBITS` = 8+`icode`); latched when input `isop` is accepted in IDLE
- `i1sps`  in  1  symbol-rate strobe (one 8PSK symbol per high cycle)
- `isop`, `ieop`  in  1  input byte framing
- `ival`  in  1  input byte valid
- `idat`  in  8  input byte
- `ordy`  out  1  packer can accept a byte this cycle
- `o1sps`  out  1  `i1sps` delayed 1 cycle
- `osop`, `oeop`, `oval`  out  1  output word framing/valid (to `tcm_enc`)
- `odat`  out  11  output word, bits above `cBITS`-1 are zero
- `ounderrun`  out  1  1-cycle pulse: word slot missed for lack of data

## Operation
- Accumulator: `acc`[23:0], bit count `cnt` 0..24. Byte accepted (`ival & ordy`) is written at `acc[cnt +: 8]`; `cnt` += 8. Stream bit 8k+j = bit j of byte k; word bit i = stream bit `cBITS`*w+i.
- `ordy` = (state==IDLE) | (state==RUN & `cnt` ≤ 16); registered-state decode, no combinational path from `ival`.
- Phase counter `ph`[1:0]: held 0 in IDLE; in RUN/TAIL increments on each `i1sps` cycle, wraps 3→0.
- Emit slot: `i1sps & ph==0` in RUN/TAIL. In RUN, emit if `cnt` ≥ `cBITS`, else `ounderrun` pulse, word counter holds. In TAIL, always emit; missing bits are zero-padded.
- Emit: `odat` = `acc[cBITS-1:0]` (zero-padded), `acc` >>= `cBITS`, `cnt` = max(`cnt`-`cBITS`, 0). A simultaneous accept + emit places the new byte at the post-shift `cnt`; no overflow is possible because accepts require `cnt` ≤ 16.
- Word counter `wcnt` 0..`pN`-1: `osop` = (`wcnt`==0), `oeop` = (`wcnt`==`pN`-1) on the emitted word.
- States:
  - IDLE: accepted bytes without `isop` are dropped. An accepted `isop` byte clears `acc`/`cnt`/`wcnt`/`ph`, latches `icode`, stores the byte, and goes to RUN, or to TAIL if `ieop` is also set.
  - RUN: accepts bytes. An accepted `ieop` goes to TAIL. A mid-packet `isop` is treated as plain data.
  - TAIL: `ordy`=0.
  - Either RUN or TAIL: emitting word `pN`-1 returns to IDLE. Residual `cnt` is discarded, and any unsent input bytes are dropped until the next `isop`.

## Timing
- Emit decision is made in the `i1sps & ph==0` cycle; `oval/osop/oeop/odat` are registered and valid the following cycle. This aligns with `o1sps`, so `oval` coincides with the first `o1sps` cycle of the 4-symbol group.
- `oval`, `osop`, `oeop`, `ounderrun` are single-cycle pulses. `odat` holds its value between pulses.
- With `i1sps` continuously high, words come out every 4 cycles; gaps in `i1sps` stretch spacing proportionally.
- Byte-accept to availability: next cycle.
- Reset: state IDLE, `acc`/`cnt`/`wcnt`/`ph` = 0. Outputs `o1sps`, `osop`, `oeop`, `oval`, `ounderrun` = 0, `odat` = 0, `ordy` = 0 while `ireset` is high and 1 in the first cycle after release. Reset mid-packet discards everything; no partial `oeop` is generated.
- `iclkena`=0: no accept, no emit, phase frozen, outputs hold their last values.

## Test plan
- `icode`=0, `pN`=4, bytes 0x01,0x02,0x03,0x04 (`isop` on first, `ieop` on last), `i1sps`=1 constant -> `odat` 0x001,0x002,0x003,0x004 at 4-cycle spacing; `osop` on word 0, `oeop` on word 3; then IDLE with `ordy`=1.
- `icode`=3, `pN`=8, 11 bytes 0xFF -> 8 words 0x7FF; `cnt`=0 at end; no `ounderrun`.
- `icode`=1, `pN`=2, bytes 0xFF,0xFF with `ieop` on second -> 0x1FF then zero-padded 0x07F with `oeop`.
- Underrun: `icode`=0, `pN`=3, one byte then 12-cycle stall -> `ounderrun` pulses at each `ph==0` slot, no `oval`, `wcnt` holds; remaining bytes resume correct words 1..2.
- Back-pressure: `icode`=2, `pN`=64, source always valid, `i1sps` toggling 3-on/5-off -> `ordy` drops whenever `cnt`>16; the output bit stream equals the input bit stream exactly, with no loss or duplication.
- `ireset` pulsed after word 2 of a `pN`=8 packet -> all outputs 0 next cycle; after release, a new `isop` packet with bytes 0xA5… produces correctly framed words starting with `osop`.

Source files
------------

// File: rtl/tcm_enc_packer.sv
// Byte-stream to 8/9/10/11-bit word packer feeding tcm_enc: LSB-first repacking,
// one word per 4D symbol (every 4th i1sps), osop/oeop framing over pN words.
module tcm_enc_packer #(
  parameter int pN = 1000
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iclkena,
  input  logic [1:0]  icode,
  input  logic        i1sps,
  input  logic        isop,
  input  logic        ieop,
  input  logic        ival,
  input  logic [7:0]  idat,
  output logic        ordy,
  output logic        o1sps,
  output logic        osop,
  output logic        oeop,
  output logic        oval,
  output logic [10:0] odat,
  output logic        ounderrun,
  output logic [1:0]  ostate
);

  localparam int WW = (pN > 1) ? $clog2(pN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_acc, w_acc_nxt, w_acc_sh;
  logic [4:0]  r_cnt, w_cnt_nxt, w_cnt_sh;
  logic [WW-1:0] r_wcnt, w_wcnt_nxt;
  logic [1:0]  r_ph, w_ph_nxt;
  logic [1:0]  r_code, w_code_nxt;

  logic        r_o1sps, r_osop, r_oeop, r_oval, r_ounderrun;
  logic [10:0] r_odat;

  logic [3:0]  w_bits;
  logic [4:0]  w_bits5;
  logic [10:0] w_mask;
  logic [10:0] w_word;
  logic        w_accept, w_slot, w_emit, w_under, w_last;

  // Handshake: a byte transfers on a clock-enabled edge where ival & ordy are both
  // high. ordy depends only on registered state (and reset), never on ival.
  assign ordy = ~ireset & ((r_state == S_IDLE) |
                           ((r_state == S_RUN) & (r_cnt <= 5'd16)));

  assign w_accept = ival & ordy;
  assign w_bits   = 4'd8 + {2'b00, r_code};
  assign w_bits5  = {1'b0, w_bits};
  assign w_mask   = 11'h7FF >> (2'd3 - r_code);
  assign w_word   = r_acc[10:0] & w_mask;
  assign w_last   = (r_wcnt == WW'(pN - 1));

  // One word slot per 4 symbols; TAIL always emits, zero-padding missing bits.
  assign w_slot  = (r_state != S_IDLE) & i1sps & (r_ph == 2'd0);
  assign w_emit  = w_slot & ((r_state == S_TAIL) | (r_cnt >= w_bits5));
  assign w_under = w_slot & (r_state == S_RUN) & (r_cnt < w_bits5);

  assign w_acc_sh = w_emit ? (r_acc >> w_bits) : r_acc;
  assign w_cnt_sh = w_emit ? ((r_cnt > w_bits5) ? (r_cnt - w_bits5) : 5'd0) : r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = w_acc_sh;
    w_cnt_nxt   = w_cnt_sh;
    w_wcnt_nxt  = r_wcnt;
    w_ph_nxt    = r_ph;
    w_code_nxt  = r_code;
    case (r_state)
      S_IDLE: begin
        w_ph_nxt = 2'd0;
        if (w_accept & isop) begin
          w_code_nxt  = icode;
          w_acc_nxt   = {16'd0, idat};
          w_cnt_nxt   = 5'd8;
          w_wcnt_nxt  = '0;
          w_state_nxt = ieop ? S_TAIL : S_RUN;
        end
      end
      S_RUN, S_TAIL: begin
        if (i1sps) w_ph_nxt = r_ph + 2'd1;
        // A byte landing with an emit goes at the post-shift count.
        if (w_accept) begin
          w_acc_nxt = w_acc_sh | ({16'd0, idat} << w_cnt_sh);
          w_cnt_nxt = w_cnt_sh + 5'd8;
          if (ieop) w_state_nxt = S_TAIL;
        end
        if (w_emit) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_wcnt_nxt  = '0;
            w_ph_nxt    = 2'd0;
            w_acc_nxt   = '0;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_wcnt_nxt = r_wcnt + WW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = 5'd0;
        w_wcnt_nxt  = '0;
        w_ph_nxt    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= 5'd0;
      r_wcnt      <= '0;
      r_ph        <= 2'd0;
      r_code      <= 2'd0;
      r_o1sps     <= 1'b0;
      r_osop      <= 1'b0;
      r_oeop      <= 1'b0;
      r_oval      <= 1'b0;
      r_ounderrun <= 1'b0;
      r_odat      <= 11'd0;
    end else if (iclkena) begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_ph        <= w_ph_nxt;
      r_code      <= w_code_nxt;
      r_o1sps     <= i1sps;
      r_oval      <= w_emit;
      r_osop      <= w_emit & (r_wcnt == '0);
      r_oeop      <= w_emit & w_last;
      r_ounderrun <= w_under;
      if (w_emit) r_odat <= w_word;
    end
  end

  assign o1sps     = r_o1sps;
  assign osop      = r_osop;
  assign oeop      = r_oeop;
  assign oval      = r_oval;
  assign odat      = r_odat;
  assign ounderrun = r_ounderrun;
  assign ostate    = r_state;

endmodule

// File: tb/tb_tcm_enc_packer.sv
// Bench for tcm_enc_packer: one instance per packet length, table of packet
// scenarios, bit-stream reference model feeding an expected-word queue.
module tb_tcm_enc_packer;

  localparam int NI = 5;
  localparam int PN[NI] = '{4, 8, 2, 3, 64};
  localparam int BUDGET = 3000;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, i1sps, isop, ieop, ival;
  logic [1:0] icode;
  logic [7:0] idat;
  int         sel;

  logic        ival_a [NI];
  logic        ordy_a [NI];
  logic        o1sps_a [NI];
  logic        osop_a [NI];
  logic        oeop_a [NI];
  logic        oval_a [NI];
  logic [10:0] odat_a [NI];
  logic        ounder_a [NI];
  logic [1:0]  ostate_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign ival_a[g] = ival & (sel == g);
    tcm_enc_packer #(.pN(PN[g])) u_dut (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .icode(icode),
      .i1sps(i1sps), .isop(isop), .ieop(ieop), .ival(ival_a[g]), .idat(idat),
      .ordy(ordy_a[g]), .o1sps(o1sps_a[g]), .osop(osop_a[g]), .oeop(oeop_a[g]),
      .oval(oval_a[g]), .odat(odat_a[g]), .ounderrun(ounder_a[g]), .ostate(ostate_a[g])
    );
  end

  // clock / reset
  initial forever #5 iclk = ~iclk;

  typedef struct {
    int sel; int pn; int code; int nbytes; int fill; int ieop_last;
    int sps_mode; int sps_delay; int stall_at; int stall_len; int ena_gap;
    int abort; int exp_first; int exp_last; int min_u; int max_u;
  } vec_t;

  vec_t        tv [8];
  logic [12:0] exp_q [$];
  logic [7:0]  bytes_m [256];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, last_cyc = 0;
  int          pkt_oval, pkt_under, n_bp, hold_viol;
  int          first_d, last_d;
  logic [15:0] prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: word w bit i is stream bit cb*w+i, zero beyond the stream end
  task automatic push_expected(input int code, input int pn, input int nbytes);
    int cb, s;
    logic [10:0] d;
    cb = 8 + code;
    for (int w = 0; w < pn; w++) begin
      d = '0;
      for (int i = 0; i < cb; i++) begin
        s = cb * w + i;
        if (s < nbytes * 8) d[i] = bytes_m[s / 8][s % 8];
      end
      exp_q.push_back({(w == 0), (w == pn - 1), d});
    end
  endtask

  // scoreboard side: called at each negedge after a clock edge
  task automatic sample(input bit ena_used, input bit spacing_on);
    logic [12:0] got, e;
    logic [15:0] cur;
    got = {osop_a[sel], oeop_a[sel], odat_a[sel]};
    cur = {oval_a[sel], osop_a[sel], oeop_a[sel], ounder_a[sel], odat_a[sel], o1sps_a[sel]};
    if (ena_used) begin
      if (oval_a[sel]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_oval", 32'(oval_a[sel]), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(got), 32'(e));
        end
        pkt_oval++;
        if (pkt_oval == 1) first_d = int'(odat_a[sel]);
        last_d = int'(odat_a[sel]);
        if (spacing_on && pkt_oval > 1) check("spacing", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
      end
      if (ounder_a[sel]) pkt_under++;
    end else if (cur != prev_out) begin
      hold_viol++;
    end
    prev_out = cur;
  endtask

  task automatic check_reset_outputs();
    check("rst_oval", 32'(oval_a[sel]), 32'd0);
    check("rst_osop", 32'(osop_a[sel]), 32'd0);
    check("rst_oeop", 32'(oeop_a[sel]), 32'd0);
    check("rst_ounderrun", 32'(ounder_a[sel]), 32'd0);
    check("rst_o1sps", 32'(o1sps_a[sel]), 32'd0);
    check("rst_odat", 32'(odat_a[sel]), 32'd0);
    check("rst_ordy", 32'(ordy_a[sel]), 32'd0);
    check("rst_state", 32'(ostate_a[sel]), 32'd0);
  endtask

  // driver: one packet per table entry, entered and left at a negedge
  task automatic run_vec(input vec_t v);
    int idx, stall_cnt, tail, target;
    bit stalled, acc_next, ena_used, fin, spacing_on;
    exp_q.delete();
    pkt_oval = 0; pkt_under = 0; n_bp = 0; hold_viol = 0;
    first_d = -1; last_d = -1;
    idx = 0; stall_cnt = 0; tail = 0; fin = 0;
    sel = v.sel;
    icode = v.code[1:0];
    spacing_on = (v.sps_mode == 0) && (v.ena_gap == 0) && (v.stall_at < 0);
    for (int k = 0; k < v.nbytes; k++) begin
      case (v.fill)
        0: bytes_m[k] = 8'(k + 1);
        1: bytes_m[k] = 8'hFF;
        2: bytes_m[k] = 8'($urandom_range(0, 255));
        default: bytes_m[k] = 8'(8'hA5 + k);
      endcase
    end
    push_expected(v.code, v.pn, v.nbytes);
    target = (v.abort > 0) ? v.abort : v.pn;
    for (int c = 0; c < BUDGET; c++) begin
      stalled = (v.stall_at >= 0) && (idx == v.stall_at + 1) && (stall_cnt < v.stall_len);
      iclkena = !((v.ena_gap != 0) && (c % 5 == 4));
      i1sps = (c >= v.sps_delay) && ((v.sps_mode == 0) || (((c - v.sps_delay) % 8) < 3));
      if (idx < v.nbytes && !stalled && !fin) begin
        ival = 1'b1;
        idat = bytes_m[idx];
        isop = (idx == 0);
        ieop = (v.ieop_last != 0) && (idx == v.nbytes - 1);
      end else begin
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
      end
      acc_next = ival && ordy_a[sel] && iclkena;
      if (ival && !ordy_a[sel]) n_bp++;
      @(posedge iclk);
      ena_used = iclkena;
      @(negedge iclk);
      cyc++;
      sample(ena_used, spacing_on);
      if (acc_next) idx++;
      if (stalled) stall_cnt++;
      if (v.abort > 0) begin
        if (pkt_oval >= v.abort) break;
      end else if (idx == v.nbytes && pkt_oval == v.pn) begin
        fin = 1;
        tail++;
        if (tail > 6) break;
      end
    end
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; iclkena = 1'b1;
    check("word_count", 32'(pkt_oval), 32'(target));
    if (v.exp_first >= 0) check("first_word", 32'(first_d), 32'(v.exp_first));
    if (v.min_u == v.max_u) check("underruns", 32'(pkt_under), 32'(v.min_u));
    else check("underruns_in_range", 32'((pkt_under >= v.min_u) && (pkt_under <= v.max_u)), 32'd1);
    if (v.abort == 0) begin
      if (v.exp_last >= 0) check("last_word", 32'(last_d), 32'(v.exp_last));
      check("idle_ordy", 32'(ordy_a[sel]), 32'd1);
      check("idle_state", 32'(ostate_a[sel]), 32'd0);
    end
    if (v.ena_gap != 0) check("hold_while_disabled", 32'(hold_viol), 32'd0);
    if (v.sps_mode == 1) check("backpressure_seen", 32'(n_bp > 0), 32'd1);
  endtask

  initial begin
    ireset = 1'b1; iclkena = 1'b1; i1sps = 1'b0; isop = 1'b0; ieop = 1'b0;
    ival = 1'b0; idat = 8'd0; icode = 2'd0; sel = 0; prev_out = '0;

    //      sel pn code nb fill eop sps dly stl len gap abt first  last   u_lo u_hi
    tv[0] = '{0, 4,  0,  4, 0,  1,  0,  0, -1,  0,  0,  0, 32'h001, 32'h004, 0, 0};
    tv[1] = '{1, 8,  3, 11, 1,  1,  0,  4, -1,  0,  0,  0, 32'h7FF, 32'h7FF, 0, 0};
    tv[2] = '{2, 2,  1,  2, 1,  1,  0,  4, -1,  0,  0,  0, 32'h1FF, 32'h07F, 0, 0};
    tv[3] = '{3, 3,  0,  3, 0,  1,  0,  0,  0, 12,  0,  0, 32'h001, 32'h003, 2, 4};
    tv[4] = '{4, 64, 2, 80, 2,  1,  1,  4, -1,  0,  0,  0, -1,      -1,      0, 0};
    tv[5] = '{0, 4,  2,  5, 2,  1,  0,  4, -1,  0,  1,  0, -1,      -1,      0, 0};
    tv[6] = '{1, 8,  0, 10, 0,  0,  0,  0, -1,  0,  0,  3, 32'h001, -1,      0, 0};
    tv[7] = '{1, 8,  0,  8, 3,  1,  0,  0, -1,  0,  0,  0, 32'h0A5, 32'h0AC, 0, 0};

    repeat (3) @(negedge iclk);
    check_reset_outputs();
    ireset = 1'b0;
    @(posedge iclk);
    @(negedge iclk);
    check("ordy_after_release", 32'(ordy_a[sel]), 32'd1);

    for (int t = 0; t < 8; t++) begin
      run_vec(tv[t]);
      if (tv[t].abort > 0) begin
        // mid-packet reset: everything discarded, no trailing oeop
        ireset = 1'b1;
        @(posedge iclk);
        @(negedge iclk);
        check_reset_outputs();
        ireset = 1'b0;
        i1sps = 1'b0;
        @(posedge iclk);
        @(negedge iclk);
        check("ordy_after_midreset", 32'(ordy_a[sel]), 32'd1);
        check("no_oval_after_reset", 32'(oval_a[sel]), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
